// File: rtl/qsys_sw_pio_irq.sv
// qsys_sw_pio_irq: Avalon-MM input PIO with synchroniser, optional debounce (QSYS_SW_PIO_DEBOUNCE_EN), edge capture and irq
module qsys_sw_pio_irq #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   logic [WIDTH-1:0] meta, sync, stable, stable_d, irq_mask, edge_capture;
   logic [WIDTH-1:0] edges, clr, mask_next, cap_next, wbits;
   logic             wr;
   logic             unused_bits;
   assign unused_bits = ^{writedata, DEBOUNCE_CYCLES[0]};
   // write decode, edge select and next value of the software-visible registers
   always_comb begin
      wr        = chipselect & ~write_n;
      wbits     = writedata[WIDTH-1:0];
      edges     = EDGE_TYPE == 0 ? stable & ~stable_d : EDGE_TYPE == 1 ? ~stable & stable_d : stable ^ stable_d;
      mask_next = (wr && address == 2'd2) ? wbits : irq_mask;
      clr       = (wr && address == 2'd3) ? wbits : '0;
      cap_next  = (edge_capture & ~clr) | edges;
   end
   // two-flop pin synchroniser and one-cycle delay of stable for edge detection
   always_ff @(posedge clk)
      if (reset) {meta, sync, stable_d} <= '0;
      else {meta, sync, stable_d} <= {in_port, meta, stable};
`ifdef QSYS_SW_PIO_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   logic [CW-1:0] cnt [WIDTH];
   // per-bit filter: a change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk)
      for (int i = 0; i < WIDTH; i++)
         if (reset) begin
            cnt[i]    <= '0;
            stable[i] <= 1'b0;
         end else if (sync[i] == stable[i]) cnt[i] <= '0;
         else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable[i] <= sync[i];
            cnt[i]    <= '0;
         end else cnt[i] <= cnt[i] + CW'(1);
`else
   // unfiltered: stable follows the synchroniser one cycle later
   always_ff @(posedge clk) stable <= reset ? '0 : sync;
`endif
   // mask and capture registers, registered read mux and level interrupt
   always_ff @(posedge clk)
      if (reset) begin
         irq_mask     <= '0;
         edge_capture <= '0;
         readdata     <= '0;
         irq          <= 1'b0;
      end else begin
         irq_mask     <= mask_next;
         edge_capture <= cap_next;
         irq          <= |(cap_next & mask_next);
         readdata     <= address == 2'd0 ? 32'(stable) : address == 2'd2 ? 32'(irq_mask) :
                         address == 2'd3 ? 32'(edge_capture) : 32'd0;
      end
endmodule

// File: tb/tb_qsys_sw_pio_irq.sv
// tb_qsys_sw_pio_irq: directed bench with a per-cycle behavioural model for EDGE_TYPE 0 and 2 instances
module tb_qsys_sw_pio_irq;
   logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
   logic [1:0]  address = 2'd0;
   logic [31:0] writedata = 32'd0;
   logic [3:0]  in_port = 4'd0;
   logic [31:0] rd0, rd2;
   logic        irq0, irq2;
   int          vectors = 0, miscompares = 0;
   bit          chk_en = 1'b0;

   typedef struct packed {
      logic [3:0]  p1, sync, stable, stable_d, mask, cap;
      logic [15:0] hist;
      logic [31:0] rd;
      logic        irq;
   } st_t;
   st_t m0 = '0, m2 = '0;

   always #5 clk = ~clk;

   qsys_sw_pio_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
   qsys_sw_pio_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

   // behavioural model: stable accepts a value once the last 4 synchronised samples all disagree with it
   function automatic st_t step(input st_t s, input int et);
      st_t        n;
      logic [3:0] e, wb, clr;
      logic       wr;
      bit         all;
      n  = s;
      wr = chipselect && !write_n;
      wb = writedata[3:0];
      e  = et == 0 ? (s.stable & ~s.stable_d) : (s.stable ^ s.stable_d);
      n.mask = (wr && address == 2'd2) ? wb : s.mask;
      clr    = (wr && address == 2'd3) ? wb : 4'h0;
      n.cap  = (s.cap & ~clr) | e;
      n.irq  = |(n.cap & n.mask);
      n.rd   = address == 2'd0 ? {28'h0, s.stable} : address == 2'd2 ? {28'h0, s.mask} :
               address == 2'd3 ? {28'h0, s.cap} : 32'h0;
      n.hist = {s.hist[11:0], s.sync};
`ifdef QSYS_SW_PIO_DEBOUNCE_EN
      for (int b = 0; b < 4; b++) begin
         all = 1'b1;
         for (int k = 0; k < 4; k++) if (n.hist[4*k+b] == s.stable[b]) all = 1'b0;
         if (all) n.stable[b] = s.sync[b];
      end
`else
      n.stable = s.sync;
`endif
      n.stable_d = s.stable;
      n.sync     = s.p1;
      n.p1       = in_port;
      return n;
   endfunction

   always @(posedge clk) begin
      m0 <= reset ? '0 : step(m0, 0);
      m2 <= reset ? '0 : step(m2, 2);
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      cmp("model rd0", rd0, m0.rd);
      cmp("model irq0", 32'(irq0), 32'(m0.irq));
      cmp("model rd2", rd2, m2.rd);
      cmp("model irq2", 32'(irq2), 32'(m2.irq));
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a);
      address = a;
      @(negedge clk);
   endtask

   initial begin
      cyc(3);
      reset = 1'b0;
      chk_en = 1'b1;
      rd(2'd0); cmp("reset data", rd0, 32'h0);
      rd(2'd2); cmp("reset mask", rd0, 32'h0);
      rd(2'd3); cmp("reset capture", rd0, 32'h0);
      cmp("reset irq", 32'(irq0), 32'h0);
      in_port = 4'h5; cyc(10);
      rd(2'd0); cmp("data 0x5", rd0, 32'h5);
      rd(2'd3); cmp("capture 0x5", rd0, 32'h5);
      in_port = 4'h0; cyc(10); wr(2'd3, 32'hF);
      in_port = 4'h1; cyc(3); in_port = 4'h0; cyc(10);
      rd(2'd3);
`ifdef QSYS_SW_PIO_DEBOUNCE_EN
      cmp("glitch filtered", rd0, 32'h0);
`else
      cmp("glitch captured", rd0, 32'h1);
`endif
      wr(2'd3, 32'hF);
      wr(2'd2, 32'h1);
      in_port = 4'h1; cyc(10);
      cmp("irq set", 32'(irq0), 32'h1);
      wr(2'd3, 32'h1);
      cmp("irq cleared", 32'(irq0), 32'h0);
      rd(2'd3); cmp("capture cleared", rd0, 32'h0);
      in_port = 4'h3;
`ifdef QSYS_SW_PIO_DEBOUNCE_EN
      cyc(6);
`else
      cyc(3);
`endif
      wr(2'd3, 32'h2);
      rd(2'd3); cmp("set wins", rd0, 32'h2);
      in_port = 4'h0; cyc(10); wr(2'd3, 32'hF);
      in_port = 4'h8; cyc(10);
      rd(2'd3); cmp("any edge rise", rd2, 32'h8);
      wr(2'd3, 32'hF);
      in_port = 4'h0; cyc(10);
      rd(2'd3); cmp("any edge fall", rd2, 32'h8);
      wr(2'd0, 32'hF); wr(2'd1, 32'hF);
      rd(2'd2); cmp("mask kept", rd0, 32'h1);
      rd(2'd0); cmp("data kept", rd0, 32'h0);
      rd(2'd1); cmp("direction", rd0, 32'h0);
      in_port = 4'hF; cyc(10);
      reset = 1'b1; cyc(1); reset = 1'b0;
      rd(2'd3); cmp("reset capture lost", rd0, 32'h0);
      cyc(10);
      rd(2'd3); cmp("held through reset", rd0, 32'hF);
      cmp("irq after reset", 32'(irq0), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
